// File: rtl/ads1292_sample_fifo_if.sv
// Four-phase request/acknowledge bus carrying one ADS1292 sample.
// The master drives data and valid; the slave answers on ack.
// Used on both sides of the sample FIFO.
interface ads1292_sample_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ack;

  modport master (output data, output valid, input ack);
  modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/ads1292_sample_fifo.sv
// Elastic FIFO between the ADS1292 reader (four-phase responder side) and the filter (four-phase initiator side).
// Latency: ack one edge after valid is sampled; output request one edge after the capture edge when empty and idle.
// Backpressure: the reader is never stalled; a sample offered while full is acked, dropped and counted.
module ads1292_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  ads1292_sample_fifo_if.slave   in_bus,
  ads1292_sample_fifo_if.master  out_bus,
  output logic [AW:0]            o_COUNT,
  output logic                   o_OVERFLOW,
  output logic [15:0]            o_DROP_CNT,
  input  logic                   i_CLR
);

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_REL
  } out_state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] out_data;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic full;
  logic empty;
  logic wr_en;
  logic drop;
  logic load;
  logic pop;

  // Full/empty come from the pre-edge count, so a same-edge pop cannot rescue a sample offered while full.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign in_bus.ack    = (in_state == IN_ACK);
  assign out_bus.valid = (out_state == OUT_REQ);
  assign out_bus.data  = out_data;
  assign o_COUNT       = count;

  // Responder: capture once per request, then wait for the reader to release valid.
  always_comb begin
    in_next = in_state;
    wr_en   = 1'b0;
    drop    = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (in_bus.valid) begin
          wr_en   = !full;
          drop    = full;
          in_next = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!in_bus.valid) begin
          in_next = IN_IDLE;
        end
      end
      default: in_next = IN_IDLE;
    endcase
  end

  // Initiator: present the oldest entry, pop on ack, wait for ack release before the next one.
  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    pop      = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          out_next = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (out_bus.ack) begin
          pop      = 1'b1;
          out_next = OUT_REL;
        end
      end
      OUT_REL: begin
        if (!out_bus.ack) begin
          out_next = OUT_IDLE;
        end
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  // State registers for both handshake machines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  // Pointers wrap naturally at DEPTH; simultaneous write and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage; contents after reset are irrelevant because the count is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_bus.data;
    end
  end

  // Output data register holds its value after the request drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= mem[rd_ptr];
    end
  end

  // Drop statistics: a drop on the clear edge counts as the first drop after the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_OVERFLOW <= 1'b0;
      o_DROP_CNT <= '0;
    end else if (drop) begin
      o_OVERFLOW <= 1'b1;
      if (i_CLR) begin
        o_DROP_CNT <= 16'd1;
      end else if (o_DROP_CNT != 16'hFFFF) begin
        o_DROP_CNT <= o_DROP_CNT + 16'd1;
      end
    end else if (i_CLR) begin
      o_OVERFLOW <= 1'b0;
      o_DROP_CNT <= '0;
    end
  end

endmodule

// File: tb/tb_ads1292_sample_fifo.sv
// Bench for the ADS1292 sample FIFO: reader and filter agents plus a queue-based reference model.
// Model observes handshakes at each falling edge and predicts count, order and drop statistics.
// Agents respond on the falling edge so the DUT samples them at the following rising edge.
module tb_ads1292_sample_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW:0]   count;
  logic          ovf;
  logic [15:0]   drop_cnt;
  logic          clr;

  ads1292_sample_fifo_if #(.DATA_W(DATA_W)) in_bus ();
  ads1292_sample_fifo_if #(.DATA_W(DATA_W)) out_bus ();

  ads1292_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_bus     (in_bus),
    .out_bus    (out_bus),
    .o_COUNT    (count),
    .o_OVERFLOW (ovf),
    .o_DROP_CNT (drop_cnt),
    .i_CLR      (clr)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] send_q[$];
  logic [31:0] out_log[$];
  logic [31:0] exp_q[$];
  bit          m_ovf;
  int          m_drop;
  bit          p_in_ack, p_out_vld;
  int          cyc, cap_cyc, rise_cyc, offer_cyc, pop_cyc, n_cap, max_cnt;

  // Agent controls
  int gap, gap_left, hold, hold_left, f_max, f_cnt;
  bit f_stall, clr_req, clr_with_offer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit quiet();
    return send_q.size() == 0 && !in_bus.valid && !in_bus.ack &&
           (f_stall || (mq.size() == 0 && !out_bus.valid && !out_bus.ack));
  endfunction

  // Interpret what happened at the last rising edge and compare against the model.
  task automatic observe();
    bit cap, pop, rise;
    cyc++;
    cap  = in_bus.ack && !p_in_ack;
    pop  = p_out_vld && !out_bus.valid;
    rise = out_bus.valid && !p_out_vld;
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (cap) begin
      cap_cyc = cyc;
      n_cap++;
      if (mq.size() == DEPTH) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end else begin
        mq.push_back(in_bus.data);
      end
    end
    if (pop) begin
      pop_cyc = cyc;
      check("pop_queue_nonempty", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) begin
        check("pop_data", out_bus.data, mq[0]);
        out_log.push_back(out_bus.data);
        void'(mq.pop_front());
      end
    end
    if (rise) begin
      rise_cyc = cyc;
      check("rise_queue_nonempty", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) check("rise_data", out_bus.data, mq[0]);
    end
    check("count", 32'(count), 32'(mq.size()));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (int'(count) > max_cnt) max_cnt = int'(count);
    p_in_ack  = in_bus.ack;
    p_out_vld = out_bus.valid;
  endtask

  // Filter and reader agents.
  task automatic drive();
    clr = 1'b0;
    if (clr_req) begin
      clr     = 1'b1;
      clr_req = 1'b0;
    end
    if (out_bus.valid && !out_bus.ack && !f_stall) begin
      if (f_cnt == 0) out_bus.ack = 1'b1;
      else f_cnt--;
    end else if (out_bus.ack && !out_bus.valid) begin
      out_bus.ack = 1'b0;
      f_cnt = int'($urandom_range(f_max, 0));
    end
    if (in_bus.valid) begin
      if (in_bus.ack) begin
        if (hold_left > 0) hold_left--;
        else in_bus.valid = 1'b0;
      end
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (!in_bus.ack && send_q.size() > 0) begin
      in_bus.data  = send_q.pop_front();
      in_bus.valid = 1'b1;
      gap_left     = gap;
      hold_left    = hold;
      offer_cyc    = cyc;
      if (clr_with_offer) begin
        clr            = 1'b1;
        clr_with_offer = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic settle(input int limit);
    int k = 0;
    while (!quiet() && k < limit) begin
      tick();
      k++;
    end
    check("settle_within_budget", 32'(quiet()), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_in_ack", 32'(in_bus.ack), 32'd0);
    check("rst_out_valid", 32'(out_bus.valid), 32'd0);
    check("rst_out_data", out_bus.data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    in_bus.valid = 1'b0;
    clr          = 1'b0;
    mq.delete();
    send_q.delete();
    m_ovf     = 1'b0;
    m_drop    = 0;
    p_in_ack  = 1'b0;
    p_out_vld = 1'b0;
    gap_left  = 0;
    hold_left = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] s [4];
    in_bus.data  = '0;
    in_bus.valid = 1'b0;
    out_bus.ack  = 1'b0;
    clr          = 1'b0;
    rstn         = 1'b1;
    gap = 2; hold = 0; f_max = 0; f_cnt = 0; f_stall = 1'b0;
    clr_req = 1'b0; clr_with_offer = 1'b0; cyc = 0; n_cap = 0; max_cnt = 0;
    do_reset();

    // Single sample through an immediately acking filter
    send_q.push_back(32'hB4DC753A);
    settle(50);
    check("ack_latency", 32'(cap_cyc - offer_cyc), 32'd1);
    check("pass_latency_1to2", 32'((rise_cyc - cap_cyc) >= 1 && (rise_cyc - cap_cyc) <= 2), 32'd1);
    check("single_out_count", 32'(out_log.size()), 32'd1);
    check("single_out_data", out_log[0], 32'hB4DC753A);
    check("single_count_zero", 32'(count), 32'd0);

    // Fill with a stalled filter, ninth sample dropped
    out_log.delete();
    n_cap = 0;
    f_stall = 1'b1;
    for (int n = 0; n < 9; n++) send_q.push_back(32'hB4DC753A + 32'(16 * n));
    settle(300);
    check("fill_captures", 32'(n_cap), 32'd9);
    check("fill_count", 32'(count), 32'd8);
    check("fill_overflow", 32'(ovf), 32'd1);
    check("fill_drop_cnt", 32'(drop_cnt), 32'd1);
    f_stall = 1'b0;
    f_cnt = 0;
    settle(300);
    check("fill_out_size", 32'(out_log.size()), 32'd8);
    for (int n = 0; n < 8 && n < out_log.size(); n++)
      check("fill_out_order", out_log[n], 32'hB4DC753A + 32'(16 * n));

    // Isolated clear
    clr_req = 1'b1;
    run(2);
    check("clr_overflow", 32'(ovf), 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Pointer wrap with random filter delay and a patient reader
    out_log.delete();
    exp_q.delete();
    max_cnt = 0;
    f_max = 5;
    gap = 8;
    for (int n = 0; n < 20; n++) begin
      logic [31:0] v;
      v = $urandom;
      send_q.push_back(v);
      exp_q.push_back(v);
    end
    settle(2000);
    check("wrap_out_size", 32'(out_log.size()), 32'd20);
    for (int n = 0; n < 20 && n < out_log.size(); n++) check("wrap_order", out_log[n], exp_q[n]);
    check("wrap_no_drop", 32'(drop_cnt), 32'd0);
    check("wrap_max_count", 32'(max_cnt <= DEPTH), 32'd1);

    // Simultaneous write and pop at count 3
    out_log.delete();
    f_max = 0;
    gap = 2;
    f_stall = 1'b1;
    for (int n = 0; n < 4; n++) s[n] = $urandom;
    for (int n = 0; n < 3; n++) send_q.push_back(s[n]);
    settle(100);
    run(4);
    check("simul_pre_count", 32'(count), 32'd3);
    check("simul_pre_valid", 32'(out_bus.valid), 32'd1);
    send_q.push_back(s[3]);
    f_stall = 1'b0;
    f_cnt = 0;
    tick();
    tick();
    check("simul_same_edge", 32'(cap_cyc), 32'(pop_cyc));
    check("simul_count", 32'(count), 32'd3);
    settle(100);
    check("simul_out_size", 32'(out_log.size()), 32'd4);
    for (int n = 0; n < 4 && n < out_log.size(); n++) check("simul_order", out_log[n], s[n]);

    // Held valid gives exactly one capture
    n_cap = 0;
    hold = 10;
    send_q.push_back(32'h5A5A0001);
    settle(100);
    hold = 0;
    check("held_captures", 32'(n_cap), 32'd1);

    // Clear on the drop edge
    f_stall = 1'b1;
    for (int n = 0; n < 9; n++) send_q.push_back(32'hC0DE0000 + 32'(n));
    settle(300);
    check("race_pre_drop", 32'(drop_cnt), 32'd1);
    clr_with_offer = 1'b1;
    send_q.push_back(32'hDEADBEEF);
    settle(50);
    check("race_overflow", 32'(ovf), 32'd1);
    check("race_drop_cnt", 32'(drop_cnt), 32'd1);
    clr_req = 1'b1;
    run(2);
    check("race_clr_overflow", 32'(ovf), 32'd0);
    check("race_clr_drop_cnt", 32'(drop_cnt), 32'd0);
    check("race_clr_keeps_data", 32'(count), 32'd8);
    f_stall = 1'b0;
    settle(300);

    // Reset mid-operation with a pending request
    f_stall = 1'b1;
    for (int n = 0; n < 5; n++) send_q.push_back(32'h12340000 + 32'(n));
    settle(200);
    check("rstmid_count", 32'(count), 32'd5);
    check("rstmid_valid", 32'(out_bus.valid), 32'd1);
    out_bus.ack = 1'b1;
    f_stall = 1'b0;
    do_reset();
    out_log.delete();
    run(10);
    check("post_rst_valid", 32'(out_bus.valid), 32'd0);
    check("post_rst_nothing_out", 32'(out_log.size()), 32'd0);
    send_q.push_back(32'h0F0F1234);
    settle(100);
    check("post_rst_out_size", 32'(out_log.size()), 32'd1);
    check("post_rst_out_data", out_log[0], 32'h0F0F1234);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
